seg7_scanner: RTL

Time-multiplexed seven-segment display driver downstream of the clock divider. Runs on the system clock and takes the divider's clock_out as a plain sampled input (scan_clk). Each rising edge of scan_clk advances to the next digit and drives that digit's anode and hex segment pattern. Displayed data is snapshotted once per full scan so no frame tears.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_hex_to_seg7.sv | 22 ++
 rtl/seg7_scanner.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scanner.
// Holds the active-low hex glyph table, the blank pattern and the
// helper that sizes the digit-index bus.
package seg7_pkg;

  // All segments off in the active-low encoding {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, entry n is the pattern for hex digit n.
  // Packed so that GLYPH_TABLE[n] selects glyph n; listed F down to 0.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Width of a bus that indexes n digits; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : seg7_pkg

// File: rtl/seg7_hex_to_seg7.sv
// hex_to_seg7: combinational nibble-to-glyph decoder.
// The glyph table is stored active-low; SEG_ACTIVE_LOW=0 inverts the
// result for common-cathode displays. i_blank forces all segments off.
module hex_to_seg7
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  logic [6:0] w_glyph_low;

  // Look up the active-low glyph, then apply the output polarity.
  always_comb begin
    w_glyph_low = i_blank ? SEG_BLANK : GLYPH_TABLE[i_nibble];
    o_seg       = SEG_ACTIVE_LOW ? w_glyph_low : ~w_glyph_low;
  end

endmodule : hex_to_seg7

// File: rtl/seg7_scanner.sv
// seg7_scanner: time-multiplexed seven-segment display driver.
//
// Runs on clock_in and treats scan_clk purely as data: each rising edge
// of scan_clk (seen while enable=1) advances to the next digit and
// registers that digit's anode, segments and decimal point.
// The displayed value is captured once per frame, on the tick that
// returns to digit 0, so a frame never mixes old and new data.
//
// Optional build macro SEG7_BLANK_EN: leading-zero blanking of digits
// above digit 0. Without it every digit always shows its hex glyph.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS     = 4,
  parameter  bit SEG_ACTIVE_LOW = 1'b1,
  localparam int IDX_W          = idx_width(NUM_DIGITS)
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IDX_W-1:0]        digit_idx
);

  // Segment and dp "off" levels follow the configured polarity.
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? SEG_BLANK : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  logic                    r_scan_prev;
  logic [IDX_W-1:0]        r_digit_idx;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;

  // Digit 0 is only ever shown on the very tick that loads the
  // snapshot, and that tick decodes straight from value/dp_mask.
  // Nibble 0 and dp bit 0 therefore never need to be stored.
  logic [4*NUM_DIGITS-1:4] r_snap;
  logic [NUM_DIGITS-1:1]   r_dp_snap;

  // ---------------------------------------------------------------
  // Next-digit datapath
  // ---------------------------------------------------------------
  logic                    w_tick;
  logic [IDX_W-1:0]        w_idx_n;
  logic                    w_frame_start;
  logic [NUM_DIGITS-1:0]   w_an_n;
  logic [3:0]              w_nibble;
  logic                    w_dp_req;
  logic                    w_blank;
  logic                    w_dp_on;
  logic                    w_dp_n;
  logic [6:0]              w_seg_n;

  // Rising edge of the sampled scan clock, gated by enable.
  assign w_tick = scan_clk & ~r_scan_prev & enable;

  // Explicit wrap so a non-power-of-two digit count never overruns.
  assign w_idx_n = (r_digit_idx == IDX_W'(NUM_DIGITS - 1))
                 ? '0
                 : r_digit_idx + 1'b1;

  assign w_frame_start = (w_idx_n == '0);

  // Active-low one-hot anode pattern for the digit about to be shown.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    w_an_n = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_n == IDX_W'(i)) begin
        w_an_n[i] = 1'b0;
      end
    end
  end

  // Select the nibble and dp request for the next digit: digit 0 comes
  // live from the inputs (it coincides with the snapshot load), the
  // rest come from the frame snapshot.
  always_comb begin
    w_nibble = value[3:0];
    w_dp_req = dp_mask[0];
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (w_idx_n == IDX_W'(i)) begin
        w_nibble = r_snap[4*i +: 4];
        w_dp_req = r_dp_snap[i];
      end
    end
  end

`ifdef SEG7_BLANK_EN
  // w_zero_from[i] is set when snapshot nibbles i..NUM_DIGITS-1 are all
  // zero; bit 0 stays clear so digit 0 is never blanked.
  logic [NUM_DIGITS-1:0] w_zero_from;

  // Scan from the most significant digit down, accumulating "all zero".
  always_comb begin : blk_zero_scan
    logic all_zero;
    w_zero_from = '0;
    all_zero    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero       = all_zero & (r_snap[4*i +: 4] == 4'h0);
      w_zero_from[i] = all_zero;
    end
  end

  // Blank the next digit when it is a leading zero.
  always_comb begin
    w_blank = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (w_idx_n == IDX_W'(i)) begin
        w_blank = w_zero_from[i];
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  // A blanked digit also drops its decimal point; apply dp polarity.
  assign w_dp_on = w_dp_req & ~w_blank;
  assign w_dp_n  = SEG_ACTIVE_LOW ? ~w_dp_on : w_dp_on;

  // Single shared decoder fed by the digit-selected nibble.
  hex_to_seg7 #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_seg_n)
  );

  // ---------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------

  // Scan-clock history, digit index and display outputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      // scan_prev resets high so a scan_clk already high at reset
      // release is not mistaken for a fresh rising edge.
      r_scan_prev <= 1'b1;
      r_digit_idx <= '0;
      r_an        <= '1;
      r_seg       <= SEG_OFF;
      r_dp        <= DP_OFF;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of block order.
      r_scan_prev <= scan_clk;
      if (w_tick) begin
        r_digit_idx <= w_idx_n;
        r_an        <= w_an_n;
        r_seg       <= w_seg_n;
        r_dp        <= w_dp_n;
      end else if (!enable) begin
        // Display off; index, segments and dp hold for resumption.
        r_an <= '1;
      end
    end
  end

  // Frame snapshot, captured on the tick that returns to digit 0.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      // NOTE: the snapshot is a handful of flops, not a RAM, so it is
      // reset to give a defined first frame after reset.
      r_snap    <= '0;
      r_dp_snap <= '0;
    end else if (w_tick && w_frame_start) begin
      r_snap    <= value[4*NUM_DIGITS-1:4];
      r_dp_snap <= dp_mask[NUM_DIGITS-1:1];
    end
  end

  assign an        = r_an;
  assign seg       = r_seg;
  assign dp        = r_dp;
  assign digit_idx = r_digit_idx;

endmodule : seg7_scanner
